// File: rtl/tcp_vlg_ka_rsp.sv
// Keep-alive responder: detects TCP keep-alive probes for one connection and requests a pure ACK.
// Optional probe counter is built only when TCP_VLG_KA_RSP_STAT_EN is defined.
package tcp_vlg_ka_rsp_pkg;
  typedef enum logic [2:0] {
    TCP_CLOSED, TCP_LISTENING, TCP_CONNECTING, TCP_CONNECTED, TCP_DISCONNECTING
  } tcp_stat_t;

  typedef struct packed {
    logic ns, cwr, ece, urg, ack, psh, rst, syn, fin;
  } tcp_flags_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    tcp_flags_t  tcp_flags;
  } tcp_hdr_t;

  typedef struct packed {
    logic        val;
    tcp_hdr_t    tcp_hdr;
    logic [15:0] pl_len;
  } rx_meta_t;

  typedef struct packed {
    logic [15:0] loc_port;
    logic [15:0] rem_port;
    logic [31:0] loc_ack;
  } tcb_t;
endpackage

module tcp_vlg_ka_rsp
  import tcp_vlg_ka_rsp_pkg::*;
#(
  parameter int ENABLE  = 1,
  parameter int HOLDOFF = 1250000,
  parameter int TIMEOUT = 125000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  tcb_t        tcb_i,
  input  rx_meta_t    rx_i,
  input  tcp_stat_t   status_i,
  output logic        send_o,
  input  logic        sent_i,
  output logic        err_o,
  output logic [15:0] probe_cnt_o
);
  localparam int MAXC = (HOLDOFF > TIMEOUT) ? HOLDOFF : TIMEOUT;
  localparam int CW   = (MAXC > 0) ? $clog2(MAXC + 1) : 1;
  localparam logic [CW-1:0] HO_LAST = CW'(HOLDOFF);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          send_q, err_q, pend_q, disc_q;
  logic          srst, probe;

  assign srst = !rst_n_i || disc_q;

  // A keep-alive probe re-sends the byte just before loc_ack (seq wraps modulo 2^32).
  assign probe = rx_i.val
              && rx_i.tcp_hdr.dst_port == tcb_i.loc_port
              && rx_i.tcp_hdr.src_port == tcb_i.rem_port
              && rx_i.tcp_hdr.tcp_flags.ack
              && !rx_i.tcp_hdr.tcp_flags.syn
              && !rx_i.tcp_hdr.tcp_flags.fin
              && !rx_i.tcp_hdr.tcp_flags.rst
              && rx_i.tcp_hdr.seq_num == (tcb_i.loc_ack - 32'd1)
              && rx_i.pl_len <= 16'd1;

  logic unused_flags;
  assign unused_flags = ^{rx_i.tcp_hdr.tcp_flags.ns, rx_i.tcp_hdr.tcp_flags.cwr,
                          rx_i.tcp_hdr.tcp_flags.ece, rx_i.tcp_hdr.tcp_flags.urg,
                          rx_i.tcp_hdr.tcp_flags.psh};

  always_ff @(posedge clk_i) begin
    disc_q <= (status_i != TCP_CONNECTED);
    if (srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      send_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (probe && ENABLE != 0) begin
            state_q <= SEND;
            send_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SEND: begin
          // Probes seen while the request is outstanding are covered by it.
          if (sent_i) begin
            state_q <= HOLD;
            send_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            state_q <= HOLD;
            send_q  <= 1'b0;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (cnt_q == HO_LAST) begin
            pend_q <= 1'b0;
            cnt_q  <= '0;
            if (pend_q || probe) begin
              state_q <= SEND;
              send_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (probe) pend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign send_o = send_q;
  assign err_o  = err_q;

`ifdef TCP_VLG_KA_RSP_STAT_EN
  logic [15:0] probe_cnt_q, probe_cnt_d;

  always_comb begin
    probe_cnt_d = probe_cnt_q;
    if (state_q == SEND && sent_i && probe_cnt_q != 16'hFFFF)
      probe_cnt_d = probe_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (srst) probe_cnt_q <= '0;
    else      probe_cnt_q <= probe_cnt_d;
  end

  assign probe_cnt_o = probe_cnt_q;
`else
  assign probe_cnt_o = '0;
`endif
endmodule

// File: tb/tb_tcp_vlg_ka_rsp.sv
// Scoreboard bench for tcp_vlg_ka_rsp: stimulus queues expected send/err edges, a monitor pops and compares.
module tb_tcp_vlg_ka_rsp;
  import tcp_vlg_ka_rsp_pkg::*;

  localparam int HOLDOFF = 10;
  localparam int TIMEOUT = 8;
  localparam logic [15:0] LOC = 16'd80;
  localparam logic [15:0] REM = 16'd5000;
  localparam int EV_RISE = 0, EV_FALL = 1, EV_ERR = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  tcb_t        tcb;
  rx_meta_t    rx;
  tcp_stat_t   status;
  logic        sent;
  logic        send_o, err_o, off_send, off_err;
  logic [15:0] probe_cnt, off_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int off_bad = 0;
  int n;
  bit mon_en = 1'b0;
  logic send_prev = 1'b0;

  typedef struct { int kind; int cyc; } ev_t;
  ev_t exp_q[$];

  tcp_vlg_ka_rsp #(.ENABLE(1), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .tcb_i(tcb), .rx_i(rx), .status_i(status),
    .send_o(send_o), .sent_i(sent), .err_o(err_o), .probe_cnt_o(probe_cnt));

  tcp_vlg_ka_rsp #(.ENABLE(0), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut_off (
    .clk_i(clk), .rst_n_i(rst_n), .tcb_i(tcb), .rx_i(rx), .status_i(status),
    .send_o(off_send), .sent_i(sent), .err_o(off_err), .probe_cnt_o(off_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_pc();
`ifdef TCP_VLG_KA_RSP_STAT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d (nothing expected)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event got kind=%0d cycle=%0d expected kind=%0d cycle=%0d", kind, cyc, e.kind, e.cyc);
      end else
        $display("event kind=%0d cycle=%0d ok", kind, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (send_o && !send_prev) check_ev(EV_RISE);
      if (!send_o && send_prev) check_ev(EV_FALL);
      if (err_o) check_ev(EV_ERR);
      if (off_send || off_err || off_cnt != 16'd0) off_bad++;
    end
    send_prev = send_o;
  end

  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, expv);
    end else
      $display("check %s = 0x%0h ok", name, act);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic at(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic drive_probe(input logic [31:0] seq, input logic [15:0] src,
                             input logic syn, input logic [15:0] len);
    rx.val                   = 1'b1;
    rx.tcp_hdr.src_port      = src;
    rx.tcp_hdr.dst_port      = LOC;
    rx.tcp_hdr.seq_num       = seq;
    rx.tcp_hdr.tcp_flags     = '0;
    rx.tcp_hdr.tcp_flags.ack = 1'b1;
    rx.tcp_hdr.tcp_flags.syn = syn;
    rx.pl_len                = len;
  endtask

  task automatic idle_rx();
    rx.val = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    sent   = 1'b0;
    status = TCP_CONNECTED;
    rx     = '0;
    tcb.loc_port = LOC;
    tcb.rem_port = REM;
    tcb.loc_ack  = 32'h1000;
    tick(3);
    chk("rst_send", {31'd0, send_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_cnt", {16'd0, probe_cnt}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    mon_en = 1'b1;
    tick(2);

    // Basic probe, sent three cycles after send rose.
    n = cyc;
    drive_probe(32'h0FFF, REM, 1'b0, 16'd0); push(EV_RISE, n + 1);
    at(n + 1); idle_rx();
    at(n + 3); sent = 1'b1; push(EV_FALL, n + 4); exp_cnt++;
    at(n + 4); sent = 1'b0;
    chk("t1_cnt", {16'd0, probe_cnt}, exp_pc());
    chk("t1_err", {31'd0, err_o}, 32'd0);
    at(n + 16);

    // Sequence wrap at loc_ack = 0, then non-probes.
    tcb.loc_ack = 32'h0;
    n = cyc;
    drive_probe(32'hFFFF_FFFF, REM, 1'b0, 16'd0); push(EV_RISE, n + 1);
    at(n + 1); idle_rx(); sent = 1'b1; push(EV_FALL, n + 2); exp_cnt++;
    at(n + 2); sent = 1'b0;
    at(n + 14); drive_probe(32'h0, REM, 1'b0, 16'd0);
    at(n + 15); idle_rx();
    at(n + 18); chk("t2_seq0_nosend", {31'd0, send_o}, 32'd0);
    drive_probe(32'hFFFF_FFFF, REM + 16'd1, 1'b0, 16'd0);
    at(n + 19); idle_rx();
    at(n + 22); chk("t2_src_nosend", {31'd0, send_o}, 32'd0);
    chk("t2_cnt", {16'd0, probe_cnt}, exp_pc());

    // Probe coincident with sent in SEND is coalesced, no pend.
    tcb.loc_ack = 32'h1000;
    n = cyc;
    drive_probe(32'h0FFF, REM, 1'b0, 16'd0); push(EV_RISE, n + 1);
    at(n + 1); sent = 1'b1; push(EV_FALL, n + 2); exp_cnt++;
    at(n + 2); idle_rx(); sent = 1'b0;
    at(n + 16); chk("t3_coalesce_nosend", {31'd0, send_o}, 32'd0);

    // Three probes during HOLD collapse into one response HOLDOFF+1 after the fall.
    n = cyc;
    drive_probe(32'h0FFF, REM, 1'b0, 16'd0); push(EV_RISE, n + 1);
    at(n + 1); idle_rx(); sent = 1'b1; push(EV_FALL, n + 2); exp_cnt++;
    at(n + 2); sent = 1'b0;
    at(n + 3); drive_probe(32'h0FFF, REM, 1'b0, 16'd0);
    at(n + 4); idle_rx();
    at(n + 5); drive_probe(32'h0FFF, REM, 1'b0, 16'd0);
    at(n + 6); idle_rx();
    at(n + 7); drive_probe(32'h0FFF, REM, 1'b0, 16'd0);
    at(n + 8); idle_rx();
    push(EV_RISE, n + 13);
    at(n + 13); sent = 1'b1; push(EV_FALL, n + 14); exp_cnt++;
    at(n + 14); sent = 1'b0;
    at(n + 27); chk("t3_cnt", {16'd0, probe_cnt}, exp_pc());

    // Timeout: send held TIMEOUT cycles, err pulse, count unchanged, next probe after holdoff.
    n = cyc;
    drive_probe(32'h0FFF, REM, 1'b0, 16'd0); push(EV_RISE, n + 1);
    at(n + 1); idle_rx();
    push(EV_FALL, n + 9); push(EV_ERR, n + 9);
    at(n + 10); chk("t4_cnt", {16'd0, probe_cnt}, exp_pc());
    chk("t4_err_one_cycle", {31'd0, err_o}, 32'd0);
    at(n + 12); drive_probe(32'h0FFF, REM, 1'b0, 16'd0);
    at(n + 13); idle_rx();
    push(EV_RISE, n + 20);
    at(n + 20); sent = 1'b1; push(EV_FALL, n + 21); exp_cnt++;
    at(n + 21); sent = 1'b0;
    at(n + 34);

    // Disconnect mid-SEND, then rst_n mid-HOLD.
    n = cyc;
    drive_probe(32'h0FFF, REM, 1'b0, 16'd0); push(EV_RISE, n + 1);
    at(n + 1); idle_rx();
    at(n + 2); status = TCP_CLOSED; push(EV_FALL, n + 4); exp_cnt = 0;
    at(n + 4); status = TCP_CONNECTED;
    chk("t5_disc_cnt", {16'd0, probe_cnt}, 32'd0);
    at(n + 6); drive_probe(32'h0FFF, REM, 1'b0, 16'd0); push(EV_RISE, n + 7);
    at(n + 7); idle_rx(); sent = 1'b1; push(EV_FALL, n + 8); exp_cnt++;
    at(n + 8); sent = 1'b0;
    chk("t5_cnt", {16'd0, probe_cnt}, exp_pc());
    at(n + 10); rst_n = 1'b0;
    at(n + 11); rst_n = 1'b1; exp_cnt = 0;
    chk("t5_rst_send", {31'd0, send_o}, 32'd0);
    chk("t5_rst_err", {31'd0, err_o}, 32'd0);
    chk("t5_rst_cnt", {16'd0, probe_cnt}, 32'd0);
    at(n + 12); drive_probe(32'h0FFF, REM, 1'b0, 16'd0); push(EV_RISE, n + 13);
    at(n + 13); idle_rx(); sent = 1'b1; push(EV_FALL, n + 14); exp_cnt++;
    at(n + 14); sent = 1'b0;
    at(n + 27);

    // SYN set and pl_len = 2 rejected; pl_len = 1 accepted.
    n = cyc;
    drive_probe(32'h0FFF, REM, 1'b1, 16'd0);
    at(n + 1); idle_rx();
    at(n + 3); drive_probe(32'h0FFF, REM, 1'b0, 16'd2);
    at(n + 4); idle_rx();
    at(n + 6); chk("t6_reject_nosend", {31'd0, send_o}, 32'd0);
    at(n + 8); drive_probe(32'h0FFF, REM, 1'b0, 16'd1); push(EV_RISE, n + 9);
    at(n + 9); idle_rx(); sent = 1'b1; push(EV_FALL, n + 10); exp_cnt++;
    at(n + 10); sent = 1'b0;
    at(n + 11); chk("t6_cnt", {16'd0, probe_cnt}, exp_pc());
    at(n + 24);

    mon_en = 1'b0;
    chk("events_left", exp_q.size(), 32'd0);
    chk("enable0_activity", off_bad, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
